ov5640_power_seq: RTL and testbench

Parametrised power-up/power-down sequencer for the OV5640 control pins (PWDN, RESETB). It is the successor to the fixed 6/2/20 ms start-only setup block. It adds:
- Delays derived from the clock frequency.
- A request/acknowledge handshake for both power-up and power-down.
- Abort of an in-flight power-up.
- Re-entry, so a sensor can be repeatedly cycled.

It sits between the system controller and the sensor pins, ahead of the SCCB register loader, which waits on `ready`.

---
 rtl/ov5640_pkg.sv | 40 ++++
 rtl/ov5640_delay_timer.sv | 37 +++
 rtl/ov5640_power_seq.sv | 216 +++++++++++++++++++++
 tb/tb_ov5640_power_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 power sequencer and the SCCB loader:
// state encoding, microsecond-to-cycle conversion and default delays.
// The OV5640_DVDD_SEQ_EN macro adds the DVDD rail states and default.
package ov5640_pkg;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_RST_WAIT = 3'd2,
    S_SETTLE   = 3'd3,
    S_READY    = 3'd4,
    S_DOWN     = 3'd5
`ifdef OV5640_DVDD_SEQ_EN
    ,
    S_DVDD_WAIT = 3'd6,
    S_DVDD_OFF  = 3'd7
`endif
  } ov5640_state_e;

  // Default delays, also used by the SCCB loader.
  localparam int OV5640_CLK_HZ_DEF    = 100_000_000;
  localparam int OV5640_T_PWR_US_DEF  = 6000;
  localparam int OV5640_T_RST_US_DEF  = 2000;
  localparam int OV5640_T_SETTLE_DEF  = 20000;
  localparam int OV5640_T_DOWN_US_DEF = 1000;
`ifdef OV5640_DVDD_SEQ_EN
  localparam int OV5640_T_DVDD_US_DEF = 1000;
`endif

  // Whole MHz times microseconds. Sub-MHz clocks give 0 cycles, and the
  // sequencer rejects 0 at elaboration.
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov5640_delay_timer.sv
// Loadable down-counter. A one-cycle i_load pulse starts a delay of i_len
// cycles. The load cycle counts as the first cycle. o_expire is high during
// the last cycle, so a client that acts on it at the next edge spends
// exactly i_len cycles in the delay.
module ov5640_delay_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Cycles left after the load cycle; counts down and holds at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len - CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Last cycle of the delay. A length of one expires in the load cycle.
  always_comb begin
    if (i_load) begin
      o_expire = (i_len == CNT_W'(1));
    end else begin
      o_expire = (r_cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/ov5640_power_seq.sv
// OV5640 PWDN/RESETB power sequencer with request/ack handshake, abort of
// an in-flight power-up and re-entry. When OV5640_DVDD_SEQ_EN is defined,
// a DVDD enable output and the rail ramp-up/ramp-down states are added.
module ov5640_power_seq
  import ov5640_pkg::*;
#(
  parameter int CLK_FREQ_HZ = OV5640_CLK_HZ_DEF,
  parameter int T_PWR_US    = OV5640_T_PWR_US_DEF,
  parameter int T_RST_US    = OV5640_T_RST_US_DEF,
  parameter int T_SETTLE_US = OV5640_T_SETTLE_DEF,
  parameter int T_DOWN_US   = OV5640_T_DOWN_US_DEF
`ifdef OV5640_DVDD_SEQ_EN
  ,
  parameter int T_DVDD_US   = OV5640_T_DVDD_US_DEF
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pwr_up_req,
  input  logic pwr_dn_req,
  output logic req_ack,
  output logic ov5640_pwdn,
  output logic ov5640_rstb,
`ifdef OV5640_DVDD_SEQ_EN
  output logic ov5640_dvdd_en,
`endif
  output logic ready,
  output logic busy,
  output logic seq_done
);

  localparam int T_PWR_CYC    = us_to_cyc(CLK_FREQ_HZ, T_PWR_US);
  localparam int T_RST_CYC    = us_to_cyc(CLK_FREQ_HZ, T_RST_US);
  localparam int T_SETTLE_CYC = us_to_cyc(CLK_FREQ_HZ, T_SETTLE_US);
  localparam int T_DOWN_CYC   = us_to_cyc(CLK_FREQ_HZ, T_DOWN_US);
`ifdef OV5640_DVDD_SEQ_EN
  localparam int T_DVDD_CYC   = us_to_cyc(CLK_FREQ_HZ, T_DVDD_US);
  localparam int MAX_CYC      = max_int(max_int(T_PWR_CYC, T_RST_CYC),
                                        max_int(max_int(T_SETTLE_CYC, T_DOWN_CYC), T_DVDD_CYC));
  localparam int MIN_OK       = (T_DVDD_CYC >= 1) ? 1 : 0;
`else
  localparam int MAX_CYC      = max_int(max_int(T_PWR_CYC, T_RST_CYC),
                                        max_int(T_SETTLE_CYC, T_DOWN_CYC));
  localparam int MIN_OK       = 1;
`endif
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LEN_PWR    = CNT_W'(T_PWR_CYC);
  localparam logic [CNT_W-1:0] LEN_RST    = CNT_W'(T_RST_CYC);
  localparam logic [CNT_W-1:0] LEN_SETTLE = CNT_W'(T_SETTLE_CYC);
  localparam logic [CNT_W-1:0] LEN_DOWN   = CNT_W'(T_DOWN_CYC);
`ifdef OV5640_DVDD_SEQ_EN
  localparam logic [CNT_W-1:0] LEN_DVDD   = CNT_W'(T_DVDD_CYC);
`endif

  // A zero-cycle delay cannot be timed, so reject it at elaboration.
  if (T_PWR_CYC < 1 || T_RST_CYC < 1 || T_SETTLE_CYC < 1 || T_DOWN_CYC < 1 || MIN_OK == 0) begin : g_bad_delay
    $error("ov5640_power_seq: every derived delay must be at least one cycle");
  end

  ov5640_state_e    r_state;
  logic             r_req_ack;
  logic             r_pwdn;
  logic             r_rstb;
  logic             r_ready;
  logic             r_busy;
  logic             r_seq_done;
  logic             r_tmr_load;
  logic [CNT_W-1:0] r_tmr_len;
  logic             w_expire;
  logic             w_abort;
`ifdef OV5640_DVDD_SEQ_EN
  logic             r_dvdd_en;

  assign w_abort = pwr_dn_req && (r_state inside {S_DVDD_WAIT, S_PWR_WAIT, S_RST_WAIT, S_SETTLE, S_READY});
  assign ov5640_dvdd_en = r_dvdd_en;
`else
  assign w_abort = pwr_dn_req && (r_state inside {S_PWR_WAIT, S_RST_WAIT, S_SETTLE, S_READY});
`endif

  assign req_ack     = r_req_ack;
  assign ov5640_pwdn = r_pwdn;
  assign ov5640_rstb = r_rstb;
  assign ready       = r_ready;
  assign busy        = r_busy;
  assign seq_done    = r_seq_done;

  ov5640_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_load   (r_tmr_load),
    .i_len    (r_tmr_len),
    .o_expire (w_expire)
  );

  // Sequencer FSM. Each timed state is entered with a timer load and left on
  // expire. A power-down request in any powered state goes to S_DOWN.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_OFF;
      r_req_ack  <= 1'b0;
      r_pwdn     <= 1'b1;
      r_rstb     <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_seq_done <= 1'b0;
      r_tmr_load <= 1'b0;
      r_tmr_len  <= '0;
`ifdef OV5640_DVDD_SEQ_EN
      r_dvdd_en  <= 1'b0;
`endif
    end else begin
      r_req_ack  <= 1'b0;
      r_seq_done <= 1'b0;
      r_tmr_load <= 1'b0;
      if (w_abort) begin
        // PWDN is left unchanged. RESETB is asserted straight away.
        r_state    <= S_DOWN;
        r_req_ack  <= 1'b1;
        r_rstb     <= 1'b0;
        r_ready    <= 1'b0;
        r_busy     <= 1'b1;
        r_tmr_load <= 1'b1;
        r_tmr_len  <= LEN_DOWN;
      end else begin
        case (r_state)
          S_OFF: begin
            if (pwr_up_req && !pwr_dn_req) begin
              r_req_ack  <= 1'b1;
              r_busy     <= 1'b1;
              r_tmr_load <= 1'b1;
`ifdef OV5640_DVDD_SEQ_EN
              r_state    <= S_DVDD_WAIT;
              r_dvdd_en  <= 1'b1;
              r_tmr_len  <= LEN_DVDD;
`else
              r_state    <= S_PWR_WAIT;
              r_tmr_len  <= LEN_PWR;
`endif
            end
          end
`ifdef OV5640_DVDD_SEQ_EN
          S_DVDD_WAIT: begin
            if (w_expire) begin
              r_state    <= S_PWR_WAIT;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= LEN_PWR;
            end
          end
`endif
          S_PWR_WAIT: begin
            if (w_expire) begin
              r_state    <= S_RST_WAIT;
              r_pwdn     <= 1'b0;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= LEN_RST;
            end
          end
          S_RST_WAIT: begin
            if (w_expire) begin
              r_state    <= S_SETTLE;
              r_rstb     <= 1'b1;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= LEN_SETTLE;
            end
          end
          S_SETTLE: begin
            if (w_expire) begin
              r_state    <= S_READY;
              r_ready    <= 1'b1;
              r_busy     <= 1'b0;
              r_seq_done <= 1'b1;
            end
          end
          S_READY: begin
            r_state <= S_READY;
          end
          S_DOWN: begin
            if (w_expire) begin
              r_pwdn     <= 1'b1;
`ifdef OV5640_DVDD_SEQ_EN
              r_state    <= S_DVDD_OFF;
              r_dvdd_en  <= 1'b0;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= LEN_DVDD;
`else
              r_state    <= S_OFF;
              r_busy     <= 1'b0;
              r_seq_done <= 1'b1;
`endif
            end
          end
`ifdef OV5640_DVDD_SEQ_EN
          S_DVDD_OFF: begin
            if (w_expire) begin
              r_state    <= S_OFF;
              r_busy     <= 1'b0;
              r_seq_done <= 1'b1;
            end
          end
`endif
          default: begin
            r_state <= S_OFF;
            r_pwdn  <= 1'b1;
            r_rstb  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Self-checking bench for ov5640_power_seq in the default build.
// Directed scenarios are followed by random request and reset traffic.
// The reference model keeps only the current phase (off / powering up /
// powering down) and the number of edges since that phase began. It derives
// every pin from that count with plain comparisons.
module tb_ov5640_power_seq;

  localparam int P_PWR = 6;
  localparam int P_RST = 2;
  localparam int P_SET = 20;
  localparam int P_DN  = 1;
  localparam int P_RDY = P_PWR + P_RST + P_SET;

  logic sys_clk    = 1'b0;
  logic sys_rst_n  = 1'b0;
  logic pwr_up_req = 1'b0;
  logic pwr_dn_req = 1'b0;
  logic req_ack, ov5640_pwdn, ov5640_rstb, ready, busy, seq_done;

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Reference model: 0 = off, 1 = powering up / ready, 2 = powering down.
  int   m_mode = 0;
  int   m_k    = 0;
  logic m_hold = 1'b1;
  logic m_ack  = 1'b0;
  logic m_done = 1'b0;

  always #5 sys_clk = ~sys_clk;

  ov5640_power_seq #(
    .CLK_FREQ_HZ (1_000_000),
    .T_PWR_US    (P_PWR),
    .T_RST_US    (P_RST),
    .T_SETTLE_US (P_SET),
    .T_DOWN_US   (P_DN)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pwr_up_req  (pwr_up_req),
    .pwr_dn_req  (pwr_dn_req),
    .req_ack     (req_ack),
    .ov5640_pwdn (ov5640_pwdn),
    .ov5640_rstb (ov5640_rstb),
    .ready       (ready),
    .busy        (busy),
    .seq_done    (seq_done)
  );

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] got %0b expected %0b at %0t", tag, phase, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic up, input logic dn, input logic rst_n);
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      m_k    = 0;
    end else begin
      case (m_mode)
        0: begin
          if (up && !dn) begin
            m_mode = 1; m_k = 0; m_ack = 1'b1;
          end
        end
        1: begin
          if (dn) begin
            m_hold = (m_k < P_PWR);
            m_mode = 2; m_k = 0; m_ack = 1'b1;
          end else begin
            m_k++;
          end
        end
        default: begin
          m_k++;
          if (m_k >= P_DN) begin
            m_mode = 0; m_k = 0; m_done = 1'b1;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic e_pwdn, e_rstb, e_ready, e_busy, e_done;
    e_pwdn  = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? (m_k < P_PWR) : m_hold;
    e_rstb  = (m_mode == 1) && (m_k >= P_PWR + P_RST);
    e_ready = (m_mode == 1) && (m_k >= P_RDY);
    e_busy  = ((m_mode == 1) && (m_k < P_RDY)) || (m_mode == 2);
    e_done  = m_done || ((m_mode == 1) && (m_k == P_RDY));
    check_eq("req_ack",  req_ack,     m_ack);
    check_eq("pwdn",     ov5640_pwdn, e_pwdn);
    check_eq("rstb",     ov5640_rstb, e_rstb);
    check_eq("ready",    ready,       e_ready);
    check_eq("busy",     busy,        e_busy);
    check_eq("seq_done", seq_done,    e_done);
  endtask

  task automatic run_cycle(input logic up, input logic dn, input logic rst_n);
    @(negedge sys_clk);
    pwr_up_req = up;
    pwr_dn_req = dn;
    sys_rst_n  = rst_n;
    @(posedge sys_clk);
    model_step(up, dn, rst_n);
    #1;
    compare_all();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    phase = "reset";
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0);
    run_idle(2);

    phase = "nominal_up";
    run_cycle(1'b1, 1'b0, 1'b1);
    run_idle(P_RDY + 3);

    phase = "up_in_ready";
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b1);

    phase = "down_from_ready";
    run_cycle(1'b0, 1'b1, 1'b1);
    run_idle(3);

    phase = "both_in_off";
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b1);
    run_idle(2);

    phase = "abort_rst_wait";
    run_cycle(1'b1, 1'b0, 1'b1);
    run_idle(6);
    run_cycle(1'b0, 1'b1, 1'b1);
    run_idle(P_RDY + 5);

    phase = "abort_pwr_wait_edge";
    run_cycle(1'b1, 1'b0, 1'b1);
    run_idle(P_PWR - 1);
    run_cycle(1'b0, 1'b1, 1'b1);
    run_idle(3);

    phase = "reset_mid_seq";
    run_cycle(1'b1, 1'b0, 1'b1);
    run_idle(14);
    run_cycle(1'b0, 1'b0, 1'b0);
    run_idle(1);
    run_cycle(1'b1, 1'b0, 1'b1);
    run_idle(P_RDY + 2);

    phase = "rearm_after_down";
    run_cycle(1'b0, 1'b1, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b1);
    run_cycle(1'b1, 1'b0, 1'b1);
    run_idle(P_RDY + 2);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      logic r_up, r_dn, r_rst;
      r_rst = ($urandom_range(0, 499) < 2) ? 1'b0 : 1'b1;
      r_up  = ($urandom_range(0, 3) == 0);
      r_dn  = ($urandom_range(0, 39) == 0);
      run_cycle(r_up, r_dn, r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
